// File: rtl/bcd_convert_seq.sv
// bcd_convert_seq: multi-cycle binary-to-BCD converter (shift-add-3, one bit per clock).
// It sits between the ALU result register and the four-digit seven-segment driver.
// A value above MAX_DEC skips conversion. It is returned as raw hex with overflow set.
// Optional build macro: LEADING_ZERO_BLANK_EN adds registered leading-zero blanking
// on blank_mask. When the macro is undefined, blank_mask is tied low.
module bcd_convert_seq #(
  parameter int unsigned BIN_W   = 16,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned MAX_DEC = 9999
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int unsigned      BCD_W    = 4 * DIGITS;
  localparam int unsigned      CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Add 3 to every digit that is 5 or more. The adjust works per nibble with no
  // carry between digits, because a digit of 9 or less never exceeds 12 after adding 3.
  function automatic logic [BCD_W-1:0] adjust_f(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (s[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = s[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = s[4*i +: 4];
      end
    end
    return r;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Set bit i when digit i and all digits above it are zero.
  // The ones digit (bit 0) is never blanked, so a value of 0 still shows "0".
  function automatic logic [DIGITS-1:0] blank_f(input logic [BCD_W-1:0] b);
    logic [DIGITS-1:0] m;
    logic              run;
    m   = {DIGITS{1'b0}};
    run = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      run  = run & (b[4*i +: 4] == 4'd0);
      m[i] = run;
    end
    return m;
  endfunction
`endif

  state_e            state_q;
  logic [BIN_W-1:0]  bin_q;
  logic [BCD_W-1:0]  scratch_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BCD_W-1:0]  bcd_out_q;
  logic              overflow_q;
  logic              done_q;
  logic              busy_q;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q;
`endif

  logic [BCD_W-1:0]  scratch_adj_s;
  logic [BCD_W-1:0]  scratch_d;
  logic [BIN_W-1:0]  bin_d;
  logic [CNT_W-1:0]  cnt_d;
  logic [BCD_W-1:0]  raw_s;
  logic              in_over_s;
  logic              last_s;

  // Datapath for one iteration: adjust the digits, then shift {scratch, captured} left by one.
  // This block also decides whether the incoming value is out of range.
  always_comb begin
    scratch_adj_s        = adjust_f(scratch_q);
    {scratch_d, bin_d}   = {scratch_adj_s, bin_q} << 1'b1;
    cnt_d                = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    raw_s                = BCD_W'(bin_in);
    in_over_s            = (32'(bin_in) > 32'(MAX_DEC));
    last_s               = (cnt_q == CNT_LAST);
  end

  // Control FSM with registered outputs.
  // bcd_out and overflow hold their previous values while a decimal conversion runs,
  // so the display does not flicker.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bin_q      <= {BIN_W{1'b0}};
      scratch_q  <= {BCD_W{1'b0}};
      cnt_q      <= {CNT_W{1'b0}};
      bcd_out_q  <= {BCD_W{1'b0}};
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q    <= {DIGITS{1'b0}};
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            bin_q  <= bin_in;
            busy_q <= 1'b1;
            if (in_over_s) begin
              bcd_out_q  <= raw_s;
              overflow_q <= 1'b1;
              done_q     <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
              blank_q    <= {DIGITS{1'b0}};
`endif
              state_q    <= ST_DONE;
            end else begin
              scratch_q <= {BCD_W{1'b0}};
              cnt_q     <= {CNT_W{1'b0}};
              done_q    <= 1'b0;
              state_q   <= ST_SHIFT;
            end
          end else begin
            done_q <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        ST_SHIFT: begin
          scratch_q <= scratch_d;
          bin_q     <= bin_d;
          cnt_q     <= cnt_d;
          if (last_s) begin
            bcd_out_q  <= scratch_d;
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q    <= blank_f(scratch_d);
`endif
            state_q    <= ST_DONE;
          end else begin
            done_q <= 1'b0;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign bcd_out  = bcd_out_q;
  assign overflow = overflow_q;
`ifdef LEADING_ZERO_BLANK_EN
  assign blank_mask = blank_q;
`else
  assign blank_mask = {DIGITS{1'b0}};
`endif

endmodule

// File: tb/tb_bcd_convert_seq.sv
// Scoreboard bench for bcd_convert_seq: stimulus pushes expected results, monitor pops on done.
module tb_bcd_convert_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;
  logic [3:0]  blank_mask;

  bcd_convert_seq dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .bin_in     (bin_in),
    .busy       (busy),
    .done       (done),
    .bcd_out    (bcd_out),
    .overflow   (overflow),
    .blank_mask (blank_mask)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] bcd;
    logic        ovf;
    logic [3:0]  blank;
    int unsigned done_cyc;
    int unsigned val;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: decimal digits by division; blanking by magnitude.
  function automatic exp_t model(input int unsigned v, input int unsigned t0);
    exp_t e;
    e.val   = v;
    e.blank = 4'd0;
    if (v > 9999) begin
      e.bcd      = v[15:0];
      e.ovf      = 1'b1;
      e.done_cyc = t0;
    end else begin
      e.bcd      = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf      = 1'b0;
      e.done_cyc = t0 + 16;
`ifdef LEADING_ZERO_BLANK_EN
      for (int i = 1; i < 4; i++) if (v < 10 ** i) e.blank[i] = 1'b1;
`endif
    end
    return e;
  endfunction

  // Monitor: each done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("bcd_out",    32'(bcd_out),    32'(mon_e.bcd));
        chk("overflow",   32'(overflow),   32'(mon_e.ovf));
        chk("blank_mask", 32'(blank_mask), 32'(mon_e.blank));
        chk("done_cycle", cyc,             mon_e.done_cyc);
      end
    end
  end

  task automatic wait_idle();
    int unsigned guard = 0;
    @(negedge clk);
    while (busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic conv(input int unsigned v);
    wait_idle();
    start  = 1'b1;
    bin_in = v[15:0];
    sb_q.push_back(model(v, cyc + 1));
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", 32'(busy), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned v;
    int unsigned t0;
    int unsigned guard;
    reset_n = 1'b0;
    start   = 1'b1;
    bin_in  = 16'd123;
    repeat (3) @(negedge clk);
    chk("reset_busy",     32'(busy),       32'd0);
    chk("reset_done",     32'(done),       32'd0);
    chk("reset_bcd",      32'(bcd_out),    32'd0);
    chk("reset_overflow", 32'(overflow),   32'd0);
    chk("reset_blank",    32'(blank_mask), 32'd0);
    start   = 1'b0;
    reset_n = 1'b1;

    conv(0);
    conv(9999);
    conv(1234);
    conv(65025);
    conv(10000);

    // A start pulse while busy must be ignored.
    conv(42);
    repeat (3) @(negedge clk);
    start  = 1'b1;
    bin_in = 16'd77;
    @(negedge clk);
    start  = 1'b0;
    conv(77);

    // Abort a conversion with reset.
    wait_idle();
    start  = 1'b1;
    bin_in = 16'd500;
    @(negedge clk);
    start  = 1'b0;
    repeat (6) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("abort_busy",     32'(busy),     32'd0);
    chk("abort_done",     32'(done),     32'd0);
    chk("abort_bcd",      32'(bcd_out),  32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    repeat (20) @(negedge clk);
    conv(500);

    conv(1005);
    conv(9);
    conv(10);
    conv(100);
    conv(1000);

    // Back-to-back: start held high, with bin_in changing while busy.
    wait_idle();
    start  = 1'b1;
    bin_in = 16'd8765;
    t0     = cyc + 1;
    sb_q.push_back(model(8765, t0));
    for (int k = 0; k < 2; k++) begin
      repeat (17) begin
        @(negedge clk);
        bin_in = 16'($urandom);
      end
      @(negedge clk);
      v      = (k == 0) ? 3019 : 40000;
      bin_in = v[15:0];
      t0     = t0 + 18;
      sb_q.push_back(model(v, t0));
    end
    @(negedge clk);
    start = 1'b0;

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 65535);
      else v = $urandom_range(0, 9999);
      conv(v);
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
